// File: rtl/graphics_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// graphics_pkg -- pointer helpers and level type shared by graphics-core FIFOs
// Revision 1.0
// ----------------------------------------------------------------------------
package graphics_pkg;

   // Wide enough for any FIFO pointer; callers slice down to ADDR_WIDTH+1 bits.
   localparam int PTR_MAX_WIDTH = 32;
   typedef logic [PTR_MAX_WIDTH-1:0] fifo_level_t;

   function automatic fifo_level_t bin2gray(input fifo_level_t bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic fifo_level_t gray2bin(input fifo_level_t gray);
      fifo_level_t bin;
      bin[PTR_MAX_WIDTH-1] = gray[PTR_MAX_WIDTH-1];
      for (int i = PTR_MAX_WIDTH-2; i >= 0; i--)
         bin[i] = bin[i+1] ^ gray[i];
      return bin;
   endfunction

endpackage
`default_nettype wire

// File: rtl/crossdomain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crossdomain -- two-flop synchronizer for gray-coded pointers
// Revision 1.0
// ----------------------------------------------------------------------------
module crossdomain #(
   parameter int SIZE = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [SIZE-1:0] data_in,
   output logic [SIZE-1:0] data_out
);

   logic [SIZE-1:0] stage1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage1   <= '0;
         data_out <= '0;
      end else begin
         stage1   <= data_in;
         data_out <= stage1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/asyncfifo_level.sv
`default_nettype none
// ----------------------------------------------------------------------------
// asyncfifo_level -- dual-clock show-ahead FIFO with level reporting and flags
// Revision 1.0
// ----------------------------------------------------------------------------
module asyncfifo_level
   import graphics_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDR_WIDTH    = 8,
   parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                  reset,
   input  logic                  write_clk,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  can_write,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   write_level,
   output logic                  overflow,
   input  logic                  read_clk,
   input  logic                  read,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  can_read,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   read_level,
   output logic                  underflow
);

   localparam int DEPTH     = 1 << ADDR_WIDTH;
   localparam int PTR_WIDTH = ADDR_WIDTH + 1;

   typedef logic [PTR_WIDTH-1:0] ptr_t;

   localparam ptr_t AFULL_LEVEL  = ptr_t'(AFULL_THRESH);
   localparam ptr_t AEMPTY_LEVEL = ptr_t'(AEMPTY_THRESH);

   function automatic ptr_t to_gray(input ptr_t bin);
      fifo_level_t wide;
      wide = bin2gray(fifo_level_t'(bin));
      return wide[PTR_WIDTH-1:0];
   endfunction

   function automatic ptr_t to_bin(input ptr_t gray);
      fifo_level_t wide;
      wide = gray2bin(fifo_level_t'(gray));
      return wide[PTR_WIDTH-1:0];
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   ptr_t wptr, wgray, rgray_sync, wptr_next, wgray_next, wlevel_next;
   ptr_t rptr, rgray, wgray_sync, rptr_next, rgray_next, rlevel_next;
   logic write_en, full_next, read_en, empty_next;

   crossdomain #(.SIZE(PTR_WIDTH)) u_rgray_sync (
      .clk      (write_clk),
      .reset    (reset),
      .data_in  (rgray),
      .data_out (rgray_sync)
   );

   crossdomain #(.SIZE(PTR_WIDTH)) u_wgray_sync (
      .clk      (read_clk),
      .reset    (reset),
      .data_in  (wgray),
      .data_out (wgray_sync)
   );

   // Flags and levels are computed from next-state pointers so they settle on the same edge.
   always_comb begin
      write_en    = write && can_write;
      wptr_next   = wptr + ptr_t'(write_en);
      wgray_next  = to_gray(wptr_next);
      full_next   = (wgray_next == {~rgray_sync[PTR_WIDTH-1:PTR_WIDTH-2],
                                    rgray_sync[PTR_WIDTH-3:0]});
      wlevel_next = wptr_next - to_bin(rgray_sync);
   end

   always_ff @(posedge write_clk or posedge reset) begin
      if (reset) begin
         wptr        <= '0;
         wgray       <= '0;
         can_write   <= 1'b1;
         almost_full <= 1'b0;
         write_level <= '0;
         overflow    <= 1'b0;
      end else begin
         wptr        <= wptr_next;
         wgray       <= wgray_next;
         can_write   <= !full_next;
         almost_full <= (wlevel_next >= AFULL_LEVEL);
         write_level <= wlevel_next;
         if (write && !can_write)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge write_clk) begin
      if (write_en)
         mem[wptr[ADDR_WIDTH-1:0]] <= write_data;
   end

   always_comb begin
      read_en     = read && can_read;
      rptr_next   = rptr + ptr_t'(read_en);
      rgray_next  = to_gray(rptr_next);
      empty_next  = (rgray_next == wgray_sync);
      rlevel_next = to_bin(wgray_sync) - rptr_next;
   end

   // Show-ahead: the output register always holds the word at the next head position.
   always_ff @(posedge read_clk or posedge reset) begin
      if (reset) begin
         rptr         <= '0;
         rgray        <= '0;
         can_read     <= 1'b0;
         almost_empty <= 1'b1;
         read_level   <= '0;
         read_data    <= '0;
         underflow    <= 1'b0;
      end else begin
         rptr         <= rptr_next;
         rgray        <= rgray_next;
         can_read     <= !empty_next;
         almost_empty <= (rlevel_next <= AEMPTY_LEVEL);
         read_level   <= rlevel_next;
         read_data    <= empty_next ? '0 : mem[rptr_next[ADDR_WIDTH-1:0]];
         if (read && !can_read)
            underflow <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_asyncfifo_level.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_asyncfifo_level -- directed bench for asyncfifo_level (depth 8, 8-bit words)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_asyncfifo_level;

   localparam int DW = 8;
   localparam int AW = 3;

   logic          reset, write_clk, read_clk, write, read;
   logic [DW-1:0] write_data, read_data;
   logic          can_write, almost_full, overflow;
   logic          can_read, almost_empty, underflow;
   logic [AW:0]   write_level, read_level;

   realtime wr_half = 5.0;
   realtime rd_half = 6.5;

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] model_q [$];
   int wr_count, rd_count;

   asyncfifo_level #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .AFULL_THRESH  (6),
      .AEMPTY_THRESH (2)
   ) dut (
      .reset        (reset),
      .write_clk    (write_clk),
      .write        (write),
      .write_data   (write_data),
      .can_write    (can_write),
      .almost_full  (almost_full),
      .write_level  (write_level),
      .overflow     (overflow),
      .read_clk     (read_clk),
      .read         (read),
      .read_data    (read_data),
      .can_read     (can_read),
      .almost_empty (almost_empty),
      .read_level   (read_level),
      .underflow    (underflow)
   );

   initial begin
      write_clk = 1'b0;
      forever #(wr_half) write_clk = ~write_clk;
   end

   initial begin
      read_clk = 1'b0;
      forever #(rd_half) read_clk = ~read_clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic check_reset_state(input string ph);
      check({ph, "_can_write"},    32'(can_write),    1);
      check({ph, "_almost_full"},  32'(almost_full),  0);
      check({ph, "_write_level"},  32'(write_level),  0);
      check({ph, "_overflow"},     32'(overflow),     0);
      check({ph, "_can_read"},     32'(can_read),     0);
      check({ph, "_almost_empty"}, 32'(almost_empty), 1);
      check({ph, "_read_level"},   32'(read_level),   0);
      check({ph, "_read_data"},    32'(read_data),    0);
      check({ph, "_underflow"},    32'(underflow),    0);
   endtask

   task automatic do_reset(input string ph);
      write = 1'b0;
      read  = 1'b0;
      reset = 1'b1;
      #3;
      check_reset_state(ph);
      repeat (2) @(posedge write_clk);
      reset = 1'b0;
      repeat (3) @(posedge read_clk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      @(posedge write_clk);
      #1;
      write      = 1'b1;
      write_data = d;
      @(posedge write_clk);
      #1;
      write = 1'b0;
   endtask

   task automatic wait_can_read(input int max_edges, output int n);
      n = 0;
      while (!can_read && n < max_edges) begin
         @(posedge read_clk);
         #1;
         n++;
      end
   endtask

   task automatic pop_one();
      read = 1'b1;
      @(posedge read_clk);
      #1;
      read = 1'b0;
   endtask

   // Concurrent writer/reader at random duty; the queue is the reference ordering.
   task automatic run_stream(input string name, input int n_words);
      int sent = 0;
      model_q.delete();
      wr_count = 0;
      rd_count = 0;
      fork
         begin : writer
            int wguard = 0;
            while (wr_count < n_words && wguard < 4000) begin
               @(posedge write_clk);
               #1;
               wguard++;
               if (write) wr_count++;
               write = 1'b0;
               check({name, "_wlevel_cons"},
                     32'(int'(write_level) >= (wr_count - rd_count)), 1);
               if (sent < n_words && can_write && $urandom_range(0, 3) != 0) begin
                  write_data = 8'(sent * 37 + 5);
                  model_q.push_back(write_data);
                  write = 1'b1;
                  sent++;
               end
            end
            write = 1'b0;
            check({name, "_wr_done"}, wr_count, n_words);
         end
         begin : reader
            int rguard = 0;
            while (rd_count < n_words && rguard < 20000) begin
               @(posedge read_clk);
               #1;
               rguard++;
               if (read) rd_count++;
               read = 1'b0;
               if (can_read && $urandom_range(0, 2) != 0) begin
                  if (model_q.size() == 0)
                     check({name, "_spurious_word"}, 32'(can_read), 0);
                  else
                     check({name, "_data"}, 32'(read_data), 32'(model_q.pop_front()));
                  read = 1'b1;
               end
            end
            read = 1'b0;
            check({name, "_rd_done"}, rd_count, n_words);
         end
      join
      repeat (6) @(posedge write_clk);
      #1;
      check({name, "_wraps"},       32'((rd_count / 8) >= 10), 1);
      check({name, "_overflow"},    32'(overflow),    0);
      check({name, "_underflow"},   32'(underflow),   0);
      check({name, "_wlevel_end"},  32'(write_level), 0);
      check({name, "_can_write"},   32'(can_write),   1);
      check({name, "_can_read"},    32'(can_read),    0);
      check({name, "_rlevel_end"},  32'(read_level),  0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset      = 1'b0;
      write      = 1'b0;
      read       = 1'b0;
      write_data = '0;
      #1;
      do_reset("rst0");

      // Fill to full, then one write too many
      @(posedge write_clk);
      #1;
      write = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         write_data = 8'(i);
         @(posedge write_clk);
         #1;
         check($sformatf("t1_wlevel_%0d", i), 32'(write_level), i);
         check($sformatf("t1_afull_%0d", i),  32'(almost_full), 32'(i >= 6));
         check($sformatf("t1_cwrite_%0d", i), 32'(can_write),   32'(i < 8));
      end
      write_data = 8'h09;
      @(posedge write_clk);
      #1;
      write = 1'b0;
      check("t1_overflow",     32'(overflow),    1);
      check("t1_wlevel_full",  32'(write_level), 8);

      // Drain the full FIFO in order
      repeat (6) @(posedge read_clk);
      #1;
      check("t2_rlevel_full", 32'(read_level),   8);
      check("t2_can_read",    32'(can_read),     1);
      check("t2_aempty_full", 32'(almost_empty), 0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t2_data_%0d", i),   32'(read_data),    i + 1);
         check($sformatf("t2_rlevel_%0d", i), 32'(read_level),   8 - i);
         check($sformatf("t2_aempty_%0d", i), 32'(almost_empty), 32'((8 - i) <= 2));
         read = 1'b1;
         @(posedge read_clk);
         #1;
         read = 1'b0;
      end
      check("t2_empty_can_read", 32'(can_read),     0);
      check("t2_empty_data",     32'(read_data),    0);
      check("t2_empty_rlevel",   32'(read_level),   0);
      check("t2_empty_aempty",   32'(almost_empty), 1);
      pop_one();
      check("t2_underflow",      32'(underflow),    1);
      check("t2_uf_rlevel",      32'(read_level),   0);
      repeat (6) @(posedge write_clk);
      #1;
      check("t2_wlevel_freed",   32'(write_level),  0);
      check("t2_can_write",      32'(can_write),    1);
      check("t2_afull_clear",    32'(almost_full),  0);

      // Single-word latency into an empty FIFO
      do_reset("rst3");
      write_word(8'hA5);
      wait_can_read(6, n);
      check("t3_latency",  32'(n <= 3),      1);
      check("t3_can_read", 32'(can_read),    1);
      check("t3_data",     32'(read_data),   32'hA5);
      check("t3_rlevel",   32'(read_level),  1);
      check("t3_aempty",   32'(almost_empty), 1);
      pop_one();
      check("t3_drained",  32'(can_read),    0);
      check("t3_zero",     32'(read_data),   0);

      do_reset("rst4");
      run_stream("t4", 100);

      // Reset with words queued discards them
      @(posedge write_clk);
      #1;
      write = 1'b1;
      for (int i = 0; i < 5; i++) begin
         write_data = 8'(8'h11 + i);
         @(posedge write_clk);
         #1;
      end
      write = 1'b0;
      repeat (4) @(posedge read_clk);
      #1;
      check("t5_queued_rlevel", 32'(read_level), 5);
      @(posedge write_clk);
      #1;
      reset = 1'b1;
      @(posedge write_clk);
      #1;
      check_reset_state("t5");
      reset = 1'b0;
      repeat (2) @(posedge write_clk);
      write_word(8'h3C);
      check("t5_wlevel", 32'(write_level), 1);
      wait_can_read(8, n);
      check("t5_can_read", 32'(can_read),   1);
      check("t5_data",     32'(read_data),  32'h3C);
      check("t5_rlevel",   32'(read_level), 1);
      pop_one();

      // Fast reader, slow writer
      reset   = 1'b1;
      wr_half = 8.5;
      rd_half = 2.0;
      do_reset("rst6");
      run_stream("t6", 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
